// File: rtl/ppi_pkg.sv
// ---------------------------------------------------------------------------
// ppi_pkg
// Shared definitions for the strobed peripheral interface: control-word field
// positions, channel mode and handshake-state enums, and the register map
// offsets that depend on the channel count.
// ---------------------------------------------------------------------------
package ppi_pkg;

   // Control word, config form (bit 7 = 1)
   localparam int CFG_FLAG = 7;
   localparam int CH_LSB   = 3;
   localparam int CH_W     = 3;
   localparam int INTE_BIT = 2;
   localparam int MODE_BIT = 1;
   localparam int DIR_BIT  = 0;

   // Control word, bit set/reset form (bit 7 = 0)
   localparam int BSR_IDX_LSB = 1;
   localparam int BSR_IDX_W   = 3;
   localparam int BSR_VAL_BIT = 0;

   typedef enum logic {
      MODE_BASIC   = 1'b0,
      MODE_STROBED = 1'b1
   } mode_e;

   // FULL means IBF for an input channel and OBF for an output channel
   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } ch_state_e;

   // Control word sits right after the channel data registers, status after it
   function automatic int ctrl_ofs(input int num_ch);
      return num_ch;
   endfunction

   function automatic int stat_ofs(input int num_ch);
      return num_ch + 1;
   endfunction

endpackage

// File: rtl/ppi_channel.sv
// ---------------------------------------------------------------------------
// ppi_channel
// One peripheral channel: configuration (mode, direction, INTE), output and
// input latches, the IDLE/FULL handshake state and STB/ACK edge detection.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   cfg_we           config write for this channel (with cfg_inte/mode/dir)
//   data_we, wdata   data write commit for this channel
//   bsr_we           bit set/reset of the output latch (bsr_idx, bsr_val)
//   rd_commit        data read commit for this channel
//   port_in          device-side input data
//   stb_n, ack_n     mode 1 input strobe / output acknowledge, active-low
//   port_out         output latch
//   port_oe          high when the channel drives its port
//   buf_full, intr   IBF/OBF flag and interrupt request
//   rd_data          value a data read of this channel returns
// ---------------------------------------------------------------------------
module ppi_channel
   import ppi_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic                 cfg_inte,
   input  mode_e                cfg_mode,
   input  logic                 cfg_dir,
   input  logic                 data_we,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 bsr_we,
   input  logic [BSR_IDX_W-1:0] bsr_idx,
   input  logic                 bsr_val,
   input  logic                 rd_commit,
   input  logic [WIDTH-1:0]     port_in,
   input  logic                 stb_n,
   input  logic                 ack_n,
   output logic [WIDTH-1:0]     port_out,
   output logic                 port_oe,
   output logic                 buf_full,
   output logic                 intr,
   output logic [WIDTH-1:0]     rd_data
);

   mode_e            mode_q, mode_d;
   logic             inte_q, inte_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] in_q, in_d;
   ch_state_e        state_q, state_d;
   logic             intr_q, intr_d;
   logic             stb_q, stb_d;
   logic             ack_q, ack_d;

   logic stb_fall, stb_rise, ack_fall, ack_rise;
   logic strobed_in, strobed_out;

   always_comb begin
      // NOTE: every signal gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      mode_d  = mode_q;
      inte_d  = inte_q;
      dir_d   = dir_q;
      out_d   = out_q;
      in_d    = in_q;
      state_d = state_q;
      intr_d  = intr_q;
      stb_d   = stb_n;
      ack_d   = ack_n;

      stb_fall    = stb_q & ~stb_n;
      stb_rise    = ~stb_q & stb_n;
      ack_fall    = ack_q & ~ack_n;
      ack_rise    = ~ack_q & ack_n;
      strobed_in  = (mode_q == MODE_STROBED) && dir_q;
      strobed_out = (mode_q == MODE_STROBED) && !dir_q;

      if (strobed_in) begin
         if (stb_rise && (state_q == FULL) && inte_q) intr_d = 1'b1;
         if (rd_commit) begin
            state_d = IDLE;
            intr_d  = 1'b0;
         end
         // A strobe while still full is dropped, unless the CPU is emptying
         // the latch in this very cycle.
         if (stb_fall && ((state_q == IDLE) || rd_commit)) begin
            in_d    = port_in;
            state_d = FULL;
         end
      end else if (strobed_out) begin
         if (ack_fall) state_d = IDLE;
         if (ack_rise && inte_q) intr_d = 1'b1;
      end

      // Placed after the ACK handling so a coincident write keeps OBF set
      if (data_we) begin
         out_d = wdata;
         if (strobed_out) begin
            state_d = FULL;
            intr_d  = 1'b0;
         end
      end

      if (bsr_we) out_d[bsr_idx] = bsr_val;

      if (cfg_we) begin
         mode_d  = cfg_mode;
         inte_d  = cfg_inte;
         dir_d   = cfg_dir;
         out_d   = '0;
         state_d = IDLE;
         intr_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         // NOTE: the input latch is reset too; it is a handful of flops, not a
         // memory array, so there is no cost argument for leaving it unreset.
         mode_q  <= MODE_BASIC;
         inte_q  <= 1'b0;
         dir_q   <= 1'b1;
         out_q   <= '0;
         in_q    <= '0;
         state_q <= IDLE;
         intr_q  <= 1'b0;
         stb_q   <= 1'b1;
         ack_q   <= 1'b1;
      end else begin
         mode_q  <= mode_d;
         inte_q  <= inte_d;
         dir_q   <= dir_d;
         out_q   <= out_d;
         in_q    <= in_d;
         state_q <= state_d;
         intr_q  <= intr_d;
         stb_q   <= stb_d;
         ack_q   <= ack_d;
      end
   end

   assign port_out = out_q;
   assign port_oe  = ~dir_q;
   assign buf_full = (state_q == FULL);
   assign intr     = intr_q;

   always_comb begin
      if (!dir_q)                      rd_data = out_q;
      else if (mode_q == MODE_STROBED) rd_data = in_q;
      else                             rd_data = port_in;
   end

endmodule

// File: rtl/ppi_strobed_ctrl.sv
// ---------------------------------------------------------------------------
// ppi_strobed_ctrl
// Parametrised synchronous peripheral interface with NUM_CH channels, each
// basic I/O or strobed handshake I/O. Owns the CPU bus decode, write/read
// commit detection, BSR routing, status register and registered read path.
//
// Ports
//   CLK, RST            clock, synchronous active-low reset
//   CS, RD, WR          active-low bus controls; A register address
//   DIN                 CPU write data
//   DOUT, DOUT_EN       registered read data and its valid/drive enable
//   PORT_IN/PORT_OUT    device-side data, channel i at slice i
//   PORT_OE             per-channel output enable
//   STB, ACK            per-channel handshake inputs, active-low
//   BUF_FULL, INTR      per-channel IBF/OBF flag and interrupt request
// ---------------------------------------------------------------------------
module ppi_strobed_ctrl
   import ppi_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int WIDTH  = 8,
   parameter int BSR_CH = 2,
   parameter int ADDR_W = 3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CS,
   input  logic                    RD,
   input  logic                    WR,
   input  logic [ADDR_W-1:0]       A,
   input  logic [WIDTH-1:0]        DIN,
   output logic [WIDTH-1:0]        DOUT,
   output logic                    DOUT_EN,
   input  logic [NUM_CH*WIDTH-1:0] PORT_IN,
   output logic [NUM_CH*WIDTH-1:0] PORT_OUT,
   output logic [NUM_CH-1:0]       PORT_OE,
   input  logic [NUM_CH-1:0]       STB,
   input  logic [NUM_CH-1:0]       ACK,
   output logic [NUM_CH-1:0]       BUF_FULL,
   output logic [NUM_CH-1:0]       INTR
);

   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_ofs(NUM_CH));
   localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(stat_ofs(NUM_CH));

   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_en_q, dout_en_d;

   logic             wr_commit, rd_commit;
   logic             cfg_wr, bsr_wr;
   logic [WIDTH-1:0] status;
   logic [WIDTH-1:0] rd_mux;
   logic [WIDTH-1:0] ch_rd_data [NUM_CH];

   // Commits fire on the first low cycle of each strobe. A simultaneous WR
   // suppresses the read entirely, including its DOUT_EN window.
   assign wr_commit = ~CS & ~WR & wr_q;
   assign rd_commit = ~CS & ~RD & rd_q & WR;
   assign cfg_wr    = wr_commit && (A == CTRL_ADDR) &&  DIN[CFG_FLAG];
   assign bsr_wr    = wr_commit && (A == CTRL_ADDR) && !DIN[CFG_FLAG];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ppi_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk       (CLK),
         .rst_n     (RST),
         .cfg_we    (cfg_wr && (DIN[CH_LSB +: CH_W] == CH_W'(i))),
         .cfg_inte  (DIN[INTE_BIT]),
         .cfg_mode  (mode_e'(DIN[MODE_BIT])),
         .cfg_dir   (DIN[DIR_BIT]),
         .data_we   (wr_commit && (A == ADDR_W'(i))),
         .wdata     (DIN),
         .bsr_we    (bsr_wr && (i == BSR_CH)),
         .bsr_idx   (DIN[BSR_IDX_LSB +: BSR_IDX_W]),
         .bsr_val   (DIN[BSR_VAL_BIT]),
         .rd_commit (rd_commit && (A == ADDR_W'(i))),
         .port_in   (PORT_IN[i*WIDTH +: WIDTH]),
         .stb_n     (STB[i]),
         .ack_n     (ACK[i]),
         .port_out  (PORT_OUT[i*WIDTH +: WIDTH]),
         .port_oe   (PORT_OE[i]),
         .buf_full  (BUF_FULL[i]),
         .intr      (INTR[i]),
         .rd_data   (ch_rd_data[i])
      );
   end

   always_comb begin
      status               = '0;
      status[NUM_CH-1:0]   = BUF_FULL;
      status[4 +: NUM_CH]  = INTR;

      // Control word and unmapped addresses fall through to zero
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (A == ADDR_W'(i)) rd_mux = ch_rd_data[i];
      end
      if (A == STAT_ADDR) rd_mux = status;

      rd_d      = RD;
      wr_d      = WR;
      dout_d    = rd_commit ? rd_mux : dout_q;
      dout_en_d = ~CS & ~RD & WR;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         rd_q      <= 1'b1;
         wr_q      <= 1'b1;
         dout_q    <= '0;
         dout_en_q <= 1'b0;
      end else begin
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         dout_q    <= dout_d;
         dout_en_q <= dout_en_d;
      end
   end

   assign DOUT    = dout_q;
   assign DOUT_EN = dout_en_q;

endmodule
